// File: rtl/wallace_mult_pipe.sv
// Pipelined Wallace-tree multiplier with valid/ready handshake and a per-operand
// signed/unsigned mode. Signed operands use a Baugh-Wooley partial-product matrix;
// the same matrix with no inversions and no correction row gives the unsigned product.
// Stage 1 registers the partial products, middle stages hold CSA tree levels,
// and the last stage registers the carry-propagate result.
module wallace_mult_pipe #(
    parameter int W      = 16,
    parameter int STAGES = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           is_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic [2:0]     inflight
);
    localparam int PW   = 2 * W;
    localparam int MAXR = W + 1;   // W partial-product rows plus one correction row

    typedef logic [MAXR-1:0][PW-1:0] rows_t;

    // Row count after lv Wallace levels (groups of three become two rows).
    function automatic int rows_after(input int lv);
        int n;
        n = MAXR;
        for (int i = 0; i < lv; i++)
            if (n > 2) n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    // Number of levels needed to bring the matrix down to two rows.
    function automatic int num_levels();
        int n;
        int l;
        n = MAXR;
        l = 0;
        for (int i = 0; i < 16; i++)
            if (n > 2) begin
                n = 2 * (n / 3) + n % 3;
                l++;
            end
        return l;
    endfunction

    localparam int NLEV = num_levels();
    localparam int MID  = (STAGES > 2) ? STAGES - 2 : 0;
    localparam int MIDD = (MID > 0) ? MID : 1;

    // A pipeline register follows level k when this returns 1. Level 0 is the raw
    // partial-product matrix; the tree levels are split evenly over the middle stages.
    function automatic logic is_bnd(input int k);
        if (STAGES == 1) return 1'b0;
        if (k == 0) return 1'b1;
        for (int s = 1; s <= MID; s++)
            if (k == (NLEV * s + MID - 1) / MIDD) return 1'b1;
        return 1'b0;
    endfunction

    // Baugh-Wooley matrix: in signed mode the cross terms touching exactly one sign
    // bit are inverted, and 2^W + 2^(2W-1) corrects for the inversions (mod 2^2W).
    function automatic rows_t pp_gen(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic s);
        rows_t r;
        logic [PW-1:0] row;
        r = '0;
        for (int i = 0; i < W; i++) begin
            row = '0;
            for (int j = 0; j < W; j++)
                row[i+j] = (x[j] & y[i]) ^ (s & ((i == W - 1) != (j == W - 1)));
            r[i] = row;
        end
        row       = '0;
        row[W]    = s;
        row[PW-1] = s;
        r[W]      = row;
        return r;
    endfunction

    // One Wallace level: full adders on each complete group of three rows, a half
    // adder on a two-row remainder, a single leftover row passes straight through.
    function automatic rows_t csa_lvl(input rows_t r, input int n);
        rows_t o;
        logic [PW-1:0] x, y, z;
        int g, m;
        o = '0;
        g = n / 3;
        m = n % 3;
        for (int i = 0; i < MAXR / 3; i++)
            if (i < g) begin
                x = r[3*i];
                y = r[3*i+1];
                z = r[3*i+2];
                o[2*i]   = x ^ y ^ z;
                o[2*i+1] = ((x & y) | (x & z) | (y & z)) << 1;
            end
        if (m == 1) begin
            o[2*g] = r[3*g];
        end else if (m == 2) begin
            x = r[3*g];
            y = r[3*g+1];
            o[2*g]   = x ^ y;
            o[2*g+1] = (x & y) << 1;
        end
        return o;
    endfunction

    function automatic logic [PW-1:0] cpa(input rows_t r);
        return r[0] + r[1];
    endfunction

    logic              adv;
    logic              xfer_in, xfer_out;
    logic [STAGES:1]   vld_q;
    logic [PW-1:0]     prod_q;
    logic [2:0]        cnt_q, cnt_d;
    rows_t             lvl_d [NLEV+1];
    rows_t             lvl_o [NLEV+1];

    // The whole pipe moves together; a stall freezes bubbles as well as data.
    assign adv      = !vld_q[STAGES] | out_ready;
    assign xfer_in  = in_valid & adv;
    assign xfer_out = vld_q[STAGES] & out_ready;

    assign lvl_d[0] = pp_gen(a, b, is_signed);

    for (genvar k = 0; k <= NLEV; k++) begin : g_lvl
        if (is_bnd(k)) begin : g_reg
            rows_t rows_q;
            // Tree-level register, loaded only when the pipe advances.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)   rows_q <= '0;
                else if (adv) rows_q <= lvl_d[k];
            end
            assign lvl_o[k] = rows_q;
        end else begin : g_thru
            assign lvl_o[k] = lvl_d[k];
        end
        if (k < NLEV) begin : g_csa
            assign lvl_d[k+1] = csa_lvl(lvl_o[k], rows_after(k));
        end
    end

    // Valid bits shift alongside the data so bubbles keep their place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else if (adv) begin
            vld_q[1] <= in_valid;
            for (int s = 2; s <= STAGES; s++) vld_q[s] <= vld_q[s-1];
        end
    end

    // Final carry-propagate add into the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   prod_q <= '0;
        else if (adv) prod_q <= cpa(lvl_o[NLEV]);
    end

    // Occupancy: up on accept, down on consume, unchanged when both or neither.
    always_comb begin
        cnt_d = cnt_q;
        if (xfer_in && !xfer_out)      cnt_d = cnt_q + 3'd1;
        else if (!xfer_in && xfer_out) cnt_d = cnt_q - 3'd1;
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign in_ready  = adv;
    assign out_valid = vld_q[STAGES];
    assign product   = prod_q;
    assign inflight  = cnt_q;
endmodule
